mcyc_ctrl_exc: RTL
==================

Name: mcyc_ctrl_exc

Overview:
- Next-generation multicycle MIPS control FSM for the multi-cycle CPU datapath. It drives every datapath mux, enable and ALU-op line from the registered instruction and the ALU and memory flags.
- Over the previous controller it adds precise traps (illegal opcode, arithmetic overflow, memory timeout), an external interrupt taken at instruction boundaries, and a per-access memory wait counter.
- It adds a 3-bit PC source select with an exception vector, and has no undriven latched outputs.

Parameters:
- MEM_TIMEOUT, 16: max consecutive not-ready cycles in a memory state before a timeout trap. 0 disables the timeout.
- OVF_TRAP, 1: 1 = add/sub/addi overflow traps; 0 = overflow ignored.
- TO_W, 8: width of the wait counter. Requires MEM_TIMEOUT < 2**TO_W.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- Inst_in, in, 32: instruction register contents.
- zero, in, 1: ALU zero flag.
- overflow, in, 1: ALU signed overflow, combinational from the current EX operands.
- MIO_ready, in, 1: memory/IO access complete this cycle.
- int_req, in, 1: level interrupt request.
- MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, out, 1 each: datapath controls.
- RegDst, MemtoReg, ALUSrcB, out, 2 each: datapath mux selects.
- PCSource, out, 3: 000 ALU, 001 ALUOut, 010 jump target, 011 rs, 100 exception vector.
- ALU_operation, out, 3: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
- EPCWrite, CauseWrite, out, 1 each: EPC/Cause register write enables.
- cause, out, 2: 00 illegal, 01 overflow, 10 memory timeout, 11 interrupt.
- int_ack, out, 1: one-cycle acknowledge of a taken interrupt.
- state_out, out, 5: current state code.

Behaviour:

State encoding and reset:
- States: IF 00, ID 01, EX_R 02, EX_MEM 03, EX_I 04, LUI_WB 05, EX_BEQ 06, EX_BNE 07, EX_JR 08, EX_JAL 09, EX_J 0A, MEM_RD 0B, MEM_WR 0C, WB_R 0D, WB_I 0E, WB_LW 0F, TRAP 10.
- Unused codes go to TRAP with cause 00.
- While reset=0: state=IF, wait counter=0, cause register=00.
- Outputs are a pure function of the registered state plus Inst_in/MIO_ready. Every output is assigned in every state; any signal not listed for a state is 0.

Decode (ID):
- op 000000 → EX_R, except funct 001000 → EX_JR.
- lw/sw → EX_MEM.
- addi/andi/ori/xori/slti → EX_I.
- lui → LUI_WB.
- j → EX_J; jal → EX_JAL; beq → EX_BEQ; bne → EX_BNE.
- Any other opcode → TRAP, cause 00.

Memory wait (IF, MEM_RD, MEM_WR):
- MIO_ready=0: stay in the state and increment the counter.
- MIO_ready=1: advance and clear the counter. IF→ID, MEM_RD→WB_LW, MEM_WR→IF.
- Counter==MEM_TIMEOUT with MIO_ready=0 and MEM_TIMEOUT≠0: go to TRAP, cause 10.
- Ready and timeout in the same cycle: ready wins.

Other transitions:
- EX_MEM → MEM_RD for lw, MEM_WR for sw.
- EX_R → WB_R; EX_I → WB_I.
- EX_R trap: OVF_TRAP=1 and overflow=1 with funct add/sub → TRAP, cause 01. The register file is not written.
- EX_I trap: same condition for addi → TRAP, cause 01.
- Boundary states: WB_R, WB_I, WB_LW, LUI_WB, EX_BEQ, EX_BNE, EX_J, EX_JR, EX_JAL and MEM_WR-ready.
- From a boundary state: int_req=1 → TRAP, cause 11; otherwise → IF.
- TRAP → IF always, and the counter is cleared.

Per-state controls:
- IF: MemRead, IRWrite=MIO_ready, CPU_MIO, ALUSrcB=01, ADD, PCWrite=MIO_ready.
- ID: ALUSrcB=11, ADD.
- EX_MEM: ALUSrcA, ALUSrcB=10, ADD.
- MEM_RD: MemRead, IorD, CPU_MIO.
- MEM_WR: MemWrite, IorD, CPU_MIO.
- WB_LW: RegWrite, MemtoReg=01.
- EX_R: ALUSrcA, ALU op by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000010 SRL, 100110 XOR; other funct ADD.
- WB_R: RegWrite, RegDst=01.
- EX_I: ALUSrcA, ALUSrcB=10, ALU op by opcode (addi ADD, andi AND, ori OR, xori XOR, slti SLT).
- WB_I: RegWrite.
- LUI_WB: RegWrite, MemtoReg=10.
- EX_BEQ: ALUSrcA, SUB, PCWriteCond, PCSource=001, Branch=1.
- EX_BNE: same as EX_BEQ but Branch=0.
- EX_J: PCWrite, PCSource=010.
- EX_JR: PCWrite, PCSource=011.
- EX_JAL: PCWrite, PCSource=010, RegWrite, RegDst=10, MemtoReg=11.
- TRAP: EPCWrite, CauseWrite, PCWrite, PCSource=100; int_ack=1 only when cause=11.

Cause output:
- cause is registered on entry to TRAP and held until the next trap.

Decomposition:
- Package mcyc_pkg: state codes, ALU op codes, PCSource codes, cause codes, opcode/funct constants.
- Sub-module mcyc_wait_timer: TO_W-bit counter. Inputs: en, ready, clear. Output: timeout.

Test Plan:
- add with overflow=0: IF(1 cycle ready)→ID→EX_R→WB_R→IF. state_out 00,01,02,0D,00; RegWrite=1 and RegDst=01 only in WB_R.
- lw with MIO_ready low 3 cycles in MEM_RD → stays 0B for 3 cycles, then WB_LW with MemtoReg=01; no trap.
- MEM_TIMEOUT=4, MIO_ready held 0 in IF → TRAP after 5 IF cycles, cause=10, PCSource=100, EPCWrite=1, then IF.
- addi with overflow=1: OVF_TRAP=1 → EX_I→TRAP, cause=01, RegWrite never asserted. OVF_TRAP=0 → WB_I.
- opcode 111111 → ID→TRAP, cause=00. int_req=1 during WB_R → TRAP, cause=11, int_ack single pulse.
- Reset asserted (reset=0) mid-MEM_WR wait → state 00 immediately, all write enables 0. After release, fetch restarts with counter 0.

Source files
------------

// File: rtl/mcyc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, ALU ops,
// PC source selects, trap causes and the opcode/funct values it decodes.
package mcyc_pkg;

    typedef enum logic [4:0] {
        S_IF     = 5'h00,
        S_ID     = 5'h01,
        S_EX_R   = 5'h02,
        S_EX_MEM = 5'h03,
        S_EX_I   = 5'h04,
        S_LUI_WB = 5'h05,
        S_EX_BEQ = 5'h06,
        S_EX_BNE = 5'h07,
        S_EX_JR  = 5'h08,
        S_EX_JAL = 5'h09,
        S_EX_J   = 5'h0A,
        S_MEM_RD = 5'h0B,
        S_MEM_WR = 5'h0C,
        S_WB_R   = 5'h0D,
        S_WB_I   = 5'h0E,
        S_WB_LW  = 5'h0F,
        S_TRAP   = 5'h10
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        PC_ALU    = 3'b000,
        PC_ALUOUT = 3'b001,
        PC_JUMP   = 3'b010,
        PC_RS     = 3'b011,
        PC_EXC    = 3'b100
    } pc_src_t;

    typedef enum logic [1:0] {
        CAUSE_ILL   = 2'b00,
        CAUSE_OVF   = 2'b01,
        CAUSE_MEMTO = 2'b10,
        CAUSE_INT   = 2'b11
    } cause_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

endpackage

// File: rtl/mcyc_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags the
// cycle on which the access has waited MEM_TIMEOUT cycles without completing.
module mcyc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    logic [TO_W-1:0] count;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= ready ? '0 : count + 1'b1;
        end
    end

    // A completing access never times out, even on the limit cycle.
    assign timeout = (MEM_TIMEOUT != 0) && en && !ready &&
                     (count == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mcyc_ctrl_exc.sv
// Multicycle MIPS control FSM with precise traps (illegal, overflow, memory
// timeout) and interrupts taken only at instruction boundaries.
module mcyc_ctrl_exc
    import mcyc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OVF_TRAP    = 1,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        int_req,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  cause,
    output logic        int_ack,
    output logic [4:0]  state_out
);

    state_t     state, next_state;
    cause_t     cause_q, trap_cause;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
    logic       boundary;
    logic       mem_state;
    logic       timeout;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_inputs;

    assign opcode = Inst_in[31:26];
    assign funct  = Inst_in[5:0];
    // Branch resolution happens in the datapath from zero and Branch.
    assign unused_inputs = ^{Inst_in[25:6], zero};

    assign mem_state = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mcyc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (mem_state),
        .ready   (MIO_ready),
        .clear   (state == S_TRAP),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IF;
            cause_q <= CAUSE_ILL;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) begin
                cause_q <= trap_cause;
            end
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        next_state  = S_IF;
        trap_cause  = CAUSE_ILL;
        boundary    = 1'b0;
        alu_op      = ALU_AND;
        pc_src      = PC_ALU;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        CPU_MIO     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        int_ack     = 1'b0;

        case (state)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = MIO_ready;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                alu_op  = ALU_ADD;
                PCWrite = MIO_ready;
                if (MIO_ready)    next_state = S_ID;
                else if (timeout) begin next_state = S_TRAP; trap_cause = CAUSE_MEMTO; end
                else              next_state = S_IF;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                          next_state = (funct == F_JR) ? S_EX_JR : S_EX_R;
                    OP_LW, OP_SW:                      next_state = S_EX_MEM;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI:                  next_state = S_EX_I;
                    OP_LUI:                            next_state = S_LUI_WB;
                    OP_J:                              next_state = S_EX_J;
                    OP_JAL:                            next_state = S_EX_JAL;
                    OP_BEQ:                            next_state = S_EX_BEQ;
                    OP_BNE:                            next_state = S_EX_BNE;
                    default: begin next_state = S_TRAP; trap_cause = CAUSE_ILL; end
                endcase
            end
            S_EX_MEM: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                alu_op     = ALU_ADD;
                next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
                if (MIO_ready)    next_state = S_WB_LW;
                else if (timeout) begin next_state = S_TRAP; trap_cause = CAUSE_MEMTO; end
                else              next_state = S_MEM_RD;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
                if (MIO_ready)    boundary = 1'b1;
                else if (timeout) begin next_state = S_TRAP; trap_cause = CAUSE_MEMTO; end
                else              next_state = S_MEM_WR;
            end
            S_WB_LW: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                boundary = 1'b1;
            end
            S_EX_R: begin
                ALUSrcA = 1'b1;
                case (funct)
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_NOR:   alu_op = ALU_NOR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SRL:   alu_op = ALU_SRL;
                    F_XOR:   alu_op = ALU_XOR;
                    default: alu_op = ALU_ADD;
                endcase
                // Trapping here keeps the faulting result out of the register file.
                if ((OVF_TRAP != 0) && overflow && ((funct == F_ADD) || (funct == F_SUB))) begin
                    next_state = S_TRAP;
                    trap_cause = CAUSE_OVF;
                end else begin
                    next_state = S_WB_R;
                end
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                boundary = 1'b1;
            end
            S_EX_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                if ((OVF_TRAP != 0) && overflow && (opcode == OP_ADDI)) begin
                    next_state = S_TRAP;
                    trap_cause = CAUSE_OVF;
                end else begin
                    next_state = S_WB_I;
                end
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                boundary = 1'b1;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                boundary = 1'b1;
            end
            S_EX_BEQ, S_EX_BNE: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                pc_src      = PC_ALUOUT;
                Branch      = (state == S_EX_BEQ);
                boundary    = 1'b1;
            end
            S_EX_J: begin
                PCWrite  = 1'b1;
                pc_src   = PC_JUMP;
                boundary = 1'b1;
            end
            S_EX_JR: begin
                PCWrite  = 1'b1;
                pc_src   = PC_RS;
                boundary = 1'b1;
            end
            S_EX_JAL: begin
                PCWrite  = 1'b1;
                pc_src   = PC_JUMP;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                boundary = 1'b1;
            end
            S_TRAP: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                PCWrite    = 1'b1;
                pc_src     = PC_EXC;
                int_ack    = (cause_q == CAUSE_INT);
                next_state = S_IF;
            end
            default: begin
                next_state = S_TRAP;
                trap_cause = CAUSE_ILL;
            end
        endcase

        // Interrupts are only taken once the current instruction has fully retired.
        if (boundary) begin
            if (int_req) begin
                next_state = S_TRAP;
                trap_cause = CAUSE_INT;
            end else begin
                next_state = S_IF;
            end
        end
    end

    assign ALU_operation = alu_op;
    assign PCSource      = pc_src;
    assign cause         = cause_q;
    assign state_out     = state;

endmodule
